// File: rtl/song_pkg.sv
// song_pkg: shared encodings, ROM word layout and FSM states
// for the buzzer song sequencer.
package song_pkg;

  localparam logic [2:0] MODE_AUTO = 3'b010;
  localparam logic [2:0] MODE_FREE = 3'b100;

  localparam logic [1:0] OCT_LOW  = 2'b01;
  localparam logic [1:0] OCT_HIGH = 2'b10;

  localparam logic [3:0] END_MARKER = 4'hF;

  localparam int ROM_W      = 10;
  localparam int W_NOTE_LSB = 6;
  localparam int W_OCT_LSB  = 4;
  localparam int W_DUR_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    GAP,
    PAUSED,
    DONE
  } state_t;

  function automatic logic [ROM_W-1:0] mk_word(
    input logic [3:0] n,
    input logic [1:0] o,
    input logic [3:0] d
  );
    return {n, o, d};
  endfunction

  function automatic logic oct_valid(
    input logic [1:0] o
  );
    return (o == OCT_LOW) || (o == OCT_HIGH);
  endfunction

  // Codes 8..14 are encoded but sound as rests.
  function automatic logic is_tone(
    input logic [3:0] n
  );
    return (n >= 4'd1) && (n <= 4'd7);
  endfunction

endpackage

// File: rtl/song_rom.sv
// song_rom: synchronous-read song table, one word per entry,
// addressed by {song, index}.
module song_rom #(
  parameter int SONG_AW   = 6,
  parameter int NUM_SONGS = 4,
  localparam int SEL_W    = $clog2(NUM_SONGS),
  localparam int AW       = SEL_W + SONG_AW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AW-1:0]             addr,
  output logic [song_pkg::ROM_W-1:0] data
);
  import song_pkg::*;

  function automatic logic [ROM_W-1:0] lookup(
    input logic [AW-1:0] a
  );
    int s;
    int i;
    s = int'(a[AW-1:SONG_AW]);
    i = int'(a[SONG_AW-1:0]);
    lookup = mk_word(END_MARKER, 2'b00, 4'd0);
    case (s)
      0: begin
        case (i)
          0: lookup = mk_word(4'd5, OCT_LOW, 4'd2);
          1: lookup = mk_word(4'd1, OCT_HIGH, 4'd1);
          default: ;
        endcase
      end
      1: begin
        case (i)
          0: lookup = mk_word(4'd3, OCT_HIGH, 4'd1);
          1: lookup = mk_word(4'd2, 2'b00, 4'd0);
          default: ;
        endcase
      end
      // No end marker: plays every entry of the page.
      2: lookup = mk_word(4'd6, OCT_LOW, 4'd1);
      3: begin
        case (i)
          0: lookup = mk_word(4'd7, OCT_HIGH, 4'd1);
          1: lookup = mk_word(4'd9, 2'b00, 4'd1);
          2: lookup = mk_word(4'd0, 2'b11, 4'd1);
          default: ;
        endcase
      end
      default: ;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      data <= lookup(addr);
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer: drives the buzzer note/octave from live keys
// or from the song ROM with timed notes and gaps.
module song_sequencer #(
  parameter int TICKS_PER_UNIT = 12_500_000,
  parameter int GAP_TICKS      = 1_250_000,
  parameter int SONG_AW        = 6,
  parameter int NUM_SONGS      = 4,
  localparam int SEL_W         = $clog2(NUM_SONGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         mode,
  input  logic [3:0]         key_note,
  input  logic [1:0]         key_octave,
  input  logic [SEL_W-1:0]   song_sel,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  output logic [3:0]         note,
  output logic [1:0]         octave_auto,
  output logic               busy,
  output logic               done,
  output logic [SONG_AW-1:0] cur_index
);
  import song_pkg::*;

  localparam int NOTE_MAX = 16 * TICKS_PER_UNIT;
  localparam int MAX_CNT  =
    (NOTE_MAX > GAP_TICKS) ? NOTE_MAX : GAP_TICKS;
  localparam int CNT_W    = $clog2(MAX_CNT);

  localparam logic [SONG_AW-1:0] IDX_LAST = '1;
  localparam logic [CNT_W-1:0]   GAP_LOAD =
    CNT_W'(GAP_TICKS - 1);

  state_t             state;
  state_t             state_n;
  state_t             ret;
  state_t             ret_n;
  state_t             nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [CNT_W-1:0]   nxt_cnt;
  logic [CNT_W-1:0]   dur_load;
  logic [SONG_AW-1:0] idx;
  logic [SONG_AW-1:0] idx_n;
  logic [SONG_AW-1:0] cur_n;
  logic [SEL_W-1:0]   sid;
  logic [SEL_W-1:0]   sid_n;
  logic [3:0]         play;
  logic [3:0]         play_n;
  logic [3:0]         note_n;
  logic [1:0]         hold;
  logic [1:0]         hold_n;
  logic [1:0]         oct_n;
  logic               done_n;
  logic               abort;

  logic [ROM_W-1:0]   word;
  logic [3:0]         w_note;
  logic [1:0]         w_oct;
  logic [3:0]         w_dur;
  logic [4:0]         units;

  song_rom #(
    .SONG_AW   (SONG_AW),
    .NUM_SONGS (NUM_SONGS)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  ({sid, idx}),
    .data  (word)
  );

  assign w_note = word[W_NOTE_LSB +: 4];
  assign w_oct  = word[W_OCT_LSB +: 2];
  assign w_dur  = word[W_DUR_LSB +: 4];

  assign units = (w_dur == 4'd0) ? 5'd16
                                 : {1'b0, w_dur};
  assign dur_load =
    CNT_W'(int'(units) * TICKS_PER_UNIT - 1);

  // The done pulse still counts as busy so a start
  // landing on it cannot slip in.
  assign busy  = (state != IDLE) | done;
  assign abort = (mode != MODE_AUTO) | stop;

  always_comb begin
    state_n = state;
    ret_n   = ret;
    cnt_n   = cnt;
    idx_n   = idx;
    sid_n   = sid;
    play_n  = play;
    hold_n  = hold;
    cur_n   = cur_index;
    done_n  = 1'b0;
    nxt     = state;
    nxt_cnt = cnt;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !done) begin
            nxt   = FETCH;
            sid_n = song_sel;
            idx_n = '0;
          end
        end
        FETCH: nxt = LOAD;
        LOAD: begin
          cur_n = idx;
          if (w_note == END_MARKER) begin
            nxt = DONE;
          end else begin
            play_n  = is_tone(w_note) ? w_note : 4'd0;
            nxt_cnt = dur_load;
            nxt     = PLAY;
            if (oct_valid(w_oct)) hold_n = w_oct;
          end
        end
        PLAY: begin
          if (cnt == '0) begin
            nxt     = GAP;
            nxt_cnt = GAP_LOAD;
          end else begin
            nxt_cnt = cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            nxt_cnt = cnt - 1'b1;
          end else if (idx == IDX_LAST) begin
            nxt = DONE;
          end else begin
            idx_n = idx + 1'b1;
            nxt   = FETCH;
          end
        end
        PAUSED: begin
          if (!pause) nxt = ret;
        end
        DONE: begin
          nxt    = IDLE;
          done_n = 1'b1;
        end
        default: nxt = IDLE;
      endcase
      // Park the step we would have taken; resume replays it.
      if (pause &&
          (state == PLAY || state == GAP) &&
          (nxt == PLAY || nxt == GAP)) begin
        ret_n   = nxt;
        state_n = PAUSED;
      end else begin
        state_n = nxt;
      end
      cnt_n = nxt_cnt;
    end
  end

  always_comb begin
    note_n = 4'd0;
    oct_n  = 2'b00;
    if (mode == MODE_FREE) begin
      note_n = key_note;
      oct_n  = oct_valid(key_octave) ? key_octave
                                     : octave_auto;
    end else if (mode == MODE_AUTO) begin
      note_n = (state_n == PLAY) ? play_n : 4'd0;
      oct_n  = hold_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ret         <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sid         <= '0;
      play        <= 4'd0;
      hold        <= OCT_LOW;
      cur_index   <= '0;
      note        <= 4'd0;
      octave_auto <= 2'b00;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      ret         <= ret_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      sid         <= sid_n;
      play        <= play_n;
      hold        <= hold_n;
      cur_index   <= cur_n;
      note        <= note_n;
      octave_auto <= oct_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed scenarios with a per-cycle
// expectation queue for the song sequencer.
module tb_song_sequencer;
  import song_pkg::*;

  localparam int TPU = 4;
  localparam int GAP = 2;
  localparam int AW  = 6;
  localparam int NS  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    mode;
  logic [3:0]    key_note;
  logic [1:0]    key_octave;
  logic [1:0]    song_sel;
  logic          start;
  logic          pause;
  logic          stop;
  logic [3:0]    note;
  logic [1:0]    octave_auto;
  logic          busy;
  logic          done;
  logic [AW-1:0] cur_index;

  always #5 clk = ~clk;

  song_sequencer #(
    .TICKS_PER_UNIT (TPU),
    .GAP_TICKS      (GAP),
    .SONG_AW        (AW),
    .NUM_SONGS      (NS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode        (mode),
    .key_note    (key_note),
    .key_octave  (key_octave),
    .song_sel    (song_sel),
    .start       (start),
    .pause       (pause),
    .stop        (stop),
    .note        (note),
    .octave_auto (octave_auto),
    .busy        (busy),
    .done        (done),
    .cur_index   (cur_index)
  );

  typedef struct {
    logic [3:0] n;
    logic [1:0] o;
    logic       co;
    logic       b;
    logic       d;
    logic [5:0] ci;
    logic       cc;
  } exp_t;

  exp_t  q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc_no = 0;
  string phase = "init";

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s/%s cyc=%0d observed=%0h expected=%0h",
             phase, tag, cyc_no, got, exp);
    end
  endtask

  task automatic push(
    input int n, input int o, input int co,
    input int b, input int d, input int ci,
    input int cc, input int reps
  );
    exp_t e;
    e.n  = 4'(n);
    e.o  = 2'(o);
    e.co = 1'(co);
    e.b  = 1'(b);
    e.d  = 1'(d);
    e.ci = 6'(ci);
    e.cc = 1'(cc);
    repeat (reps) q.push_back(e);
  endtask

  // fetch+load, audible note, then the silent gap
  task automatic push_entry(
    input int n, input int o, input int dur, input int idx
  );
    push(0, 0, 0, 1, 0, 0, 0, 2);
    push(n, o, 1, 1, 0, idx, 1, dur * TPU);
    push(0, o, 1, 1, 0, idx, 1, GAP);
  endtask

  task automatic push_end();
    push(0, 0, 0, 1, 0, 0, 0, 3);
    push(0, 0, 0, 1, 1, 0, 0, 1);
    push(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic check_out();
    exp_t e;
    if (q.size() == 0) return;
    e = q.pop_front();
    chk("note", 32'(note), 32'(e.n));
    chk("busy", 32'(busy), 32'(e.b));
    chk("done", 32'(done), 32'(e.d));
    if (e.co) chk("octave", 32'(octave_auto), 32'(e.o));
    if (e.cc) chk("cur_index", 32'(cur_index), 32'(e.ci));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_no++;
    check_out();
  endtask

  task automatic drain();
    while (q.size() > 0) cyc();
  endtask

  task automatic go(input int sel);
    song_sel = 2'(sel);
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc_no);
    $fatal(1, "timeout");
  end

  initial begin
    mode       = MODE_AUTO;
    key_note   = 4'd0;
    key_octave = 2'b00;
    song_sel   = 2'd0;
    start      = 1'b0;
    pause      = 1'b0;
    stop       = 1'b0;

    phase = "reset";
    repeat (2) @(posedge clk);
    #1;
    chk("note", 32'(note), 0);
    chk("octave", 32'(octave_auto), 0);
    chk("busy", 32'(busy), 0);
    chk("done", 32'(done), 0);
    chk("cur_index", 32'(cur_index), 0);
    rst_n = 1'b1;
    cyc();

    phase = "free";
    mode = MODE_FREE;
    key_note = 4'd3;
    key_octave = OCT_HIGH;
    start = 1'b1;
    push(3, 2, 1, 0, 0, 0, 0, 1);
    cyc();
    start = 1'b0;
    key_note = 4'd9;
    key_octave = 2'b11;
    push(9, 2, 1, 0, 0, 0, 0, 2);
    cyc();
    cyc();

    phase = "idle_mode";
    mode = 3'b000;
    start = 1'b1;
    push(0, 0, 1, 0, 0, 0, 0, 2);
    cyc();
    start = 1'b0;
    cyc();
    mode = MODE_AUTO;
    key_note = 4'd0;
    cyc();

    phase = "basic";
    push_entry(5, 1, 2, 0);
    push_entry(1, 2, 1, 1);
    push_end();
    go(0);
    repeat (3) cyc();
    song_sel = 2'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    drain();

    phase = "oct_hold_dur0";
    push_entry(3, 2, 1, 0);
    push_entry(2, 2, 16, 1);
    push_end();
    go(1);
    drain();

    phase = "rests";
    push_entry(7, 2, 1, 0);
    push_entry(0, 2, 1, 1);
    push_entry(0, 2, 1, 2);
    push_end();
    go(3);
    drain();

    phase = "pause";
    push(0, 0, 0, 1, 0, 0, 0, 2);
    push(5, 1, 1, 1, 0, 0, 1, 5);
    push(0, 1, 1, 1, 0, 0, 1, 10);
    push(5, 1, 1, 1, 0, 0, 1, 3);
    push(0, 1, 1, 1, 0, 0, 1, GAP);
    push_entry(1, 2, 1, 1);
    push_end();
    go(0);
    repeat (6) cyc();
    pause = 1'b1;
    repeat (10) cyc();
    pause = 1'b0;
    drain();

    phase = "stop_start";
    push(0, 0, 0, 1, 0, 0, 0, 2);
    push(5, 1, 1, 1, 0, 0, 1, 3);
    push(0, 0, 0, 0, 0, 0, 0, 4);
    go(0);
    repeat (4) cyc();
    stop = 1'b1;
    start = 1'b1;
    cyc();
    stop = 1'b0;
    start = 1'b0;
    drain();

    phase = "mode_switch";
    push(0, 0, 0, 1, 0, 0, 0, 2);
    push(5, 1, 1, 1, 0, 0, 1, 2);
    push(6, 1, 1, 0, 0, 0, 0, 3);
    go(0);
    repeat (3) cyc();
    mode = MODE_FREE;
    key_note = 4'd6;
    key_octave = OCT_LOW;
    drain();
    mode = MODE_AUTO;
    key_note = 4'd0;
    repeat (2) cyc();

    phase = "implicit_end";
    for (int i = 0; i < 64; i++) push_entry(6, 1, 1, i);
    push(0, 0, 0, 1, 0, 63, 1, 1);
    push(0, 0, 0, 1, 1, 63, 1, 1);
    push(0, 0, 0, 0, 0, 63, 1, 1);
    go(2);
    drain();

    phase = "reset_mid_gap";
    push_entry(5, 1, 2, 0);
    push(0, 0, 0, 1, 0, 0, 0, 2);
    push(1, 2, 1, 1, 0, 1, 1, TPU);
    push(0, 2, 1, 1, 0, 1, 1, 1);
    go(0);
    repeat (18) cyc();
    rst_n = 1'b0;
    #1;
    chk("note", 32'(note), 0);
    chk("octave", 32'(octave_auto), 0);
    chk("busy", 32'(busy), 0);
    chk("done", 32'(done), 0);
    chk("cur_index", 32'(cur_index), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    chk("busy", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
